// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: parametrised UART receiver with parity and
// framing checks feeding a first-word-fall-through receive FIFO.
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk_i,
  input  logic                          rst,
  input  logic                          rxd_i,
  input  logic [15:0]                   prescale_i,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic                          busy_o,
  output logic                          frame_error_o,
  output logic                          parity_error_o,
  output logic                          overrun_error_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t                state_q;
  logic                  sync1_q;
  logic                  line_q;
  logic [18:0]           cnt_q;
  logic [15:0]           pre_q;
  logic [3:0]            bit_q;
  logic [DATA_WIDTH-1:0] shreg_q;
  logic                  par_q;
  logic                  stop_bad_q;
  logic                  busy_q;
  logic                  ferr_q;
  logic                  perr_q;
  logic                  oerr_q;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_q;
  logic [AW-1:0]         rd_q;
  logic [CW-1:0]         count_q;

  logic        tick;
  logic        last_stop;
  logic        stop_ok;
  logic        par_ok;
  logic        full;
  logic        pop;
  logic        push;
  logic [18:0] bit_len;
  logic [18:0] half_len;

  always_ff @(posedge clk_i) begin
    if (rst) begin
      sync1_q <= 1'b1;
      line_q  <= 1'b1;
    end else begin
      sync1_q <= rxd_i;
      line_q  <= sync1_q;
    end
  end

  assign tick      = (cnt_q == 19'd0);
  assign bit_len   = {pre_q, 3'b000} - 19'd1;
  assign half_len  = {1'b0, prescale_i, 2'b00} - 19'd1;
  assign last_stop = (state_q == S_STOP) && tick &&
                     (bit_q == 4'(STOP_BITS - 1));
  assign stop_ok   = !stop_bad_q && line_q;
  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign pop       = m_axis_tvalid && m_axis_tready;

  // par_q holds the XOR of data bits and the parity bit
  always_comb begin
    par_ok = 1'b1;
    if (PARITY == 1) par_ok = par_q;
    else if (PARITY == 2) par_ok = !par_q;
  end

  assign push = last_stop && stop_ok && par_ok && (!full || pop);

  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      pre_q      <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      stop_bad_q <= 1'b0;
      busy_q     <= 1'b0;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
      oerr_q     <= 1'b0;
    end else begin
      ferr_q <= 1'b0;
      perr_q <= 1'b0;
      oerr_q <= 1'b0;
      if (!tick) cnt_q <= cnt_q - 19'd1;
      case (state_q)
        S_IDLE: begin
          if (!line_q && prescale_i != 16'd0) begin
            pre_q   <= prescale_i;
            cnt_q   <= half_len;
            state_q <= S_START;
            busy_q  <= 1'b1;
          end
        end
        S_START: begin
          if (tick) begin
            if (line_q) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              cnt_q   <= bit_len;
              bit_q   <= '0;
              par_q   <= 1'b0;
              state_q <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (tick) begin
            shreg_q <= {line_q, shreg_q[DATA_WIDTH-1:1]};
            par_q   <= par_q ^ line_q;
            cnt_q   <= bit_len;
            if (bit_q == 4'(DATA_WIDTH - 1)) begin
              bit_q      <= '0;
              stop_bad_q <= 1'b0;
              state_q    <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_q <= bit_q + 4'd1;
            end
          end
        end
        S_PARITY: begin
          if (tick) begin
            par_q   <= par_q ^ line_q;
            cnt_q   <= bit_len;
            state_q <= S_STOP;
          end
        end
        S_STOP: begin
          if (tick) begin
            if (!last_stop) begin
              stop_bad_q <= stop_bad_q | !line_q;
              bit_q      <= bit_q + 4'd1;
              cnt_q      <= bit_len;
            end else if (!stop_ok) begin
              ferr_q  <= 1'b1;
              state_q <= S_BREAK;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              if (!par_ok) perr_q <= 1'b1;
              else if (full && !pop) oerr_q <= 1'b1;
            end
          end
        end
        S_BREAK: begin
          if (line_q) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q] <= shreg_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign m_axis_tvalid   = (count_q != '0);
  assign m_axis_tdata    = m_axis_tvalid ? mem_q[rd_q] : '0;
  assign fifo_count_o    = count_q;
  assign busy_o          = busy_q;
  assign frame_error_o   = ferr_q;
  assign parity_error_o  = perr_q;
  assign overrun_error_o = oerr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: vector table, corner sequences and a
// randomized frame model for uart_rx_fifo in three configurations.
module tb_uart_rx_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] prescale = 16'd1;

  always #5 clk = ~clk;

  logic       rxd_a = 1'b1, trdy_a = 1'b1;
  logic [7:0] td_a;
  logic [4:0] cnt_a;
  logic       tv_a, busy_a, fe_a, pe_a, oe_a;

  logic       rxd_b = 1'b1, trdy_b = 1'b1;
  logic [7:0] td_b;
  logic [2:0] cnt_b;
  logic       tv_b, busy_b, fe_b, pe_b, oe_b;

  logic       rxd_c = 1'b1, trdy_c = 1'b1;
  logic [6:0] td_c;
  logic [1:0] cnt_c;
  logic       tv_c, busy_c, fe_c, pe_c, oe_c;

  uart_rx_fifo dut_a (
    .clk_i(clk), .rst(rst), .rxd_i(rxd_a),
    .prescale_i(prescale),
    .m_axis_tdata(td_a), .m_axis_tvalid(tv_a),
    .m_axis_tready(trdy_a), .fifo_count_o(cnt_a),
    .busy_o(busy_a), .frame_error_o(fe_a),
    .parity_error_o(pe_a), .overrun_error_o(oe_a)
  );

  uart_rx_fifo #(
    .DATA_WIDTH(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)
  ) dut_b (
    .clk_i(clk), .rst(rst), .rxd_i(rxd_b),
    .prescale_i(prescale),
    .m_axis_tdata(td_b), .m_axis_tvalid(tv_b),
    .m_axis_tready(trdy_b), .fifo_count_o(cnt_b),
    .busy_o(busy_b), .frame_error_o(fe_b),
    .parity_error_o(pe_b), .overrun_error_o(oe_b)
  );

  uart_rx_fifo #(
    .DATA_WIDTH(7), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(2)
  ) dut_c (
    .clk_i(clk), .rst(rst), .rxd_i(rxd_c),
    .prescale_i(prescale),
    .m_axis_tdata(td_c), .m_axis_tvalid(tv_c),
    .m_axis_tready(trdy_c), .fifo_count_o(cnt_c),
    .busy_o(busy_c), .frame_error_o(fe_c),
    .parity_error_o(pe_c), .overrun_error_o(oe_c)
  );

  int checks = 0;
  int failures = 0;
  int fe_n[3] = '{0, 0, 0};
  int pe_n[3] = '{0, 0, 0};
  int oe_n[3] = '{0, 0, 0};
  int busy_n = 0;
  int lat;
  logic [7:0] pop_a[$];
  logic [7:0] pop_b[$];
  logic [7:0] pop_c[$];

  always @(negedge clk) begin
    if (tv_a && trdy_a) pop_a.push_back(td_a);
    if (tv_b && trdy_b) pop_b.push_back(td_b);
    if (tv_c && trdy_c) pop_c.push_back(8'(td_c));
    fe_n[0] += int'(fe_a);
    pe_n[0] += int'(pe_a);
    oe_n[0] += int'(oe_a);
    fe_n[1] += int'(fe_b);
    pe_n[1] += int'(pe_b);
    oe_n[1] += int'(oe_b);
    fe_n[2] += int'(fe_c);
    pe_n[2] += int'(pe_c);
    oe_n[2] += int'(oe_c);
    busy_n  += int'(busy_a);
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_rxd(input int w, input logic v);
    case (w)
      0:       rxd_a = v;
      1:       rxd_b = v;
      default: rxd_c = v;
    endcase
  endtask

  // bit 0 goes out first; each bit lasts 8*prescale cycles
  task automatic drive(input int w, input logic [15:0] bits,
                       input int n);
    for (int i = 0; i < n; i++) begin
      set_rxd(w, bits[i]);
      repeat (8 * int'(prescale)) @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [15:0] fa(input logic [7:0] d,
                                     input logic s);
    return {6'b0, s, d, 1'b0};
  endfunction

  function automatic logic [15:0] fb(input logic [7:0] d,
                                     input logic pb,
                                     input logic [1:0] s);
    return {4'b0, s[1], s[0], pb, d, 1'b0};
  endfunction

  function automatic logic [15:0] fc(input logic [6:0] d,
                                     input logic pb,
                                     input logic s);
    return {6'b0, s, pb, d, 1'b0};
  endfunction

  function automatic logic [31:0] pk(input int f, input int p,
                                     input int o, input int n,
                                     input int d);
    return {8'b0, 4'(f), 4'(p), 4'(o), 4'(n), 8'(d)};
  endfunction

  // one frame plus a bit of idle; result packs error counts,
  // number of characters popped and the first one popped
  task automatic frame(input int w, input logic [15:0] bits,
                       input int n, output logic [31:0] code);
    int f0, p0, o0, sz;
    logic [7:0] d;
    f0 = fe_n[w];
    p0 = pe_n[w];
    o0 = oe_n[w];
    case (w)
      0:       pop_a.delete();
      1:       pop_b.delete();
      default: pop_c.delete();
    endcase
    drive(w, bits, n);
    drive(w, 16'hFFFF, 1);
    d = 8'h00;
    case (w)
      0: begin
        sz = pop_a.size();
        if (sz > 0) d = pop_a[0];
      end
      1: begin
        sz = pop_b.size();
        if (sz > 0) d = pop_b[0];
      end
      default: begin
        sz = pop_c.size();
        if (sz > 0) d = pop_c[0];
      end
    endcase
    code = pk(fe_n[w] - f0, pe_n[w] - p0, oe_n[w] - o0,
              sz, int'(d));
  endtask

  typedef struct {
    logic [7:0] d;
    logic       pb;
    logic [1:0] st;
    int         ef;
    int         ep;
    int         en;
    logic [7:0] ed;
  } vec_t;

  vec_t tbl[9];

  logic [31:0] code;
  logic [31:0] ecode;
  int e0, b0, o0;
  logic [7:0] exp_drain[5];
  logic [6:0] rd7;
  logic rpb, rst_ok;

  initial begin
    // even parity, 2 stop bits: {stop2, stop1}
    tbl[0] = '{8'h03, 1'b1, 2'b11, 0, 1, 0, 8'h00};
    tbl[1] = '{8'h03, 1'b0, 2'b11, 0, 0, 1, 8'h03};
    tbl[2] = '{8'h07, 1'b1, 2'b11, 0, 0, 1, 8'h07};
    tbl[3] = '{8'h00, 1'b0, 2'b11, 0, 0, 1, 8'h00};
    tbl[4] = '{8'hFF, 1'b1, 2'b11, 0, 1, 0, 8'h00};
    tbl[5] = '{8'h80, 1'b1, 2'b10, 1, 0, 0, 8'h00};
    tbl[6] = '{8'h81, 1'b1, 2'b01, 1, 0, 0, 8'h00};
    tbl[7] = '{8'hFE, 1'b1, 2'b11, 0, 0, 1, 8'hFE};
    tbl[8] = '{8'h55, 1'b1, 2'b11, 0, 1, 0, 8'h00};

    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", 32'(tv_a), 32'd0);
    check("rst_tdata", 32'(td_a), 32'd0);
    check("rst_count", 32'(cnt_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_errs", {29'd0, fe_a, pe_a, oe_a}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_b", {tv_b, cnt_b, busy_b, fe_b, pe_b, oe_b},
          32'd0);
    check("idle_c", {tv_c, cnt_c, busy_c, fe_c, pe_c, oe_c},
          32'd0);

    // 0xA5 8N1 at P=1, with pin-to-tvalid latency
    e0 = fe_n[0] + pe_n[0] + oe_n[0];
    pop_a.delete();
    fork
      drive(0, fa(8'hA5, 1'b1), 10);
      begin
        lat = 0;
        while (!tv_a && lat < 300) begin
          @(negedge clk);
          lat++;
        end
        lat = lat - 1;
      end
    join
    drive(0, 16'hFFFF, 1);
    check("a5_latency", 32'(lat), 32'(2 + 4 + 8 * 9 + 1));
    check("a5_pops", 32'(pop_a.size()), 32'd1);
    check("a5_data", (pop_a.size() > 0) ? 32'(pop_a[0]) : 32'hDEAD,
          32'hA5);
    check("a5_count", 32'(cnt_a), 32'd0);
    check("a5_errs", 32'(fe_n[0] + pe_n[0] + oe_n[0] - e0), 32'd0);

    // glitch shorter than half a bit
    e0 = fe_n[0] + pe_n[0] + oe_n[0];
    b0 = busy_n;
    pop_a.delete();
    rxd_a = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rxd_a = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("glitch_busy_seen", 32'(busy_n - b0 > 0), 32'd1);
    check("glitch_busy_end", 32'(busy_a), 32'd0);
    check("glitch_pops", 32'(pop_a.size()), 32'd0);
    check("glitch_errs", 32'(fe_n[0] + pe_n[0] + oe_n[0] - e0),
          32'd0);

    // bad stop bit followed by a held-low line
    e0 = fe_n[0];
    o0 = pe_n[0] + oe_n[0];
    pop_a.delete();
    drive(0, fa(8'h3C, 1'b0), 10);
    repeat (100) @(posedge clk);
    #1;
    check("break_busy", 32'(busy_a), 32'd1);
    check("break_fe", 32'(fe_n[0] - e0), 32'd1);
    check("break_other", 32'(pe_n[0] + oe_n[0] - o0), 32'd0);
    check("break_pops", 32'(pop_a.size()), 32'd0);
    rxd_a = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("break_release", 32'(busy_a), 32'd0);
    frame(0, fa(8'h5A, 1'b1), 10, code);
    check("after_break_5a", code, pk(0, 0, 0, 1, 8'h5A));

    // even-parity / two-stop vector table
    trdy_b = 1'b1;
    for (int i = 0; i < 9; i++) begin
      frame(1, fb(tbl[i].d, tbl[i].pb, tbl[i].st), 12, code);
      check($sformatf("vec%0d", i), code,
            pk(tbl[i].ef, tbl[i].ep, 0, tbl[i].en, int'(tbl[i].ed)));
    end

    // fill depth-4 FIFO, overrun on the fifth character
    trdy_b = 1'b0;
    pop_b.delete();
    o0 = oe_n[1];
    for (int d = 1; d <= 5; d++) begin
      drive(1, fb(8'(d), ^(8'(d)), 2'b11), 12);
      drive(1, 16'hFFFF, 1);
      if (d == 4) check("full_count", 32'(cnt_b), 32'd4);
    end
    check("overrun_pulse", 32'(oe_n[1] - o0), 32'd1);
    check("overrun_state", {tv_b, td_b, cnt_b}, {1'b1, 8'h01, 3'd4});

    // pop exactly on the push cycle while full
    fork
      drive(1, fb(8'h06, 1'b0, 2'b11), 12);
      begin
        repeat (2 + 4 + 8 * 11 + 1 - 1) @(posedge clk);
        #1;
        trdy_b = 1'b1;
        @(posedge clk);
        #1;
        trdy_b = 1'b0;
      end
    join
    drive(1, 16'hFFFF, 1);
    check("coincide_no_oe", 32'(oe_n[1] - o0), 32'd1);
    check("coincide_count", 32'(cnt_b), 32'd4);
    check("coincide_pop", {24'(pop_b.size()), pop_b[0]},
          {24'd1, 8'h01});
    check("coincide_head", 32'(td_b), 32'h02);

    trdy_b = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("drain_b2b", 32'(cnt_b), 32'd0);
    exp_drain = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h06};
    check("drain_len", 32'(pop_b.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("drain%0d", i),
            (pop_b.size() > i) ? 32'(pop_b[i]) : 32'hDEAD,
            32'(exp_drain[i]));
    end

    // reset during DATA with two entries buffered
    trdy_b = 1'b0;
    drive(1, fb(8'h11, 1'b0, 2'b11), 12);
    drive(1, 16'hFFFF, 1);
    drive(1, fb(8'h22, 1'b0, 2'b11), 12);
    drive(1, 16'hFFFF, 1);
    check("pre_rst_count", 32'(cnt_b), 32'd2);
    drive(1, fb(8'h33, 1'b0, 2'b11), 4);
    check("pre_rst_busy", 32'(busy_b), 32'd1);
    e0 = fe_n[1] + pe_n[1] + oe_n[1];
    rst = 1'b1;
    rxd_b = 1'b1;
    @(posedge clk);
    #1;
    rst_ok = 1'b1;
    check("rst_mid_outs",
          {tv_b, td_b, cnt_b, busy_b, fe_b, pe_b, oe_b}, 32'd0);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("rst_mid_errs", 32'(fe_n[1] + pe_n[1] + oe_n[1] - e0),
          32'd0);
    trdy_b = 1'b1;
    frame(1, fb(8'hC3, 1'b0, 2'b11), 12, code);
    check("after_rst_c3", code, pk(0, 0, 0, 1, 8'hC3));

    // random 7O1 frames against a frame-level model
    for (int i = 0; i < 30; i++) begin
      prescale = 16'($urandom_range(3, 1));
      rd7 = 7'($urandom);
      rpb = ~^rd7;
      if ($urandom_range(3, 0) == 0) rpb = ~rpb;
      rst_ok = ($urandom_range(7, 0) != 0);
      if (!rst_ok) ecode = pk(1, 0, 0, 0, 0);
      else if ((^rd7 ^ rpb) != 1'b1) ecode = pk(0, 1, 0, 0, 0);
      else ecode = pk(0, 0, 0, 1, int'(rd7));
      frame(2, fc(rd7, rpb, rst_ok), 10, code);
      check($sformatf("rand%0d", i), code, ecode);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver with a built-in receive FIFO. It generalises the team's fixed 8N1 receiver with configurable data width, parity mode and stop-bit count. Each received character is checked for parity and framing errors, and good characters are buffered in a first-word-fall-through FIFO. It sits between the board RX pin and AXI-Stream consumers such as the ALU command parser, so the consumer can stall for a full burst without losing characters.

## Interface
Parameters:
- DATA_WIDTH, 8: character bits, legal range 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: legal values 1 or 2.
- FIFO_DEPTH, 16: number of entries; power of two, at least 2.

Ports:
- clk_i  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- rxd_i  in  1  asynchronous serial line, idle high.
- prescale_i  in  16  bit time = prescale_i*8 clk_i cycles.
- m_axis_tdata  out  DATA_WIDTH  FIFO head character.
- m_axis_tvalid  out  1  FIFO not empty.
- m_axis_tready  in  1  consumer pop.
- fifo_count_o  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- busy_o  out  1  high in any state except IDLE.
- frame_error_o  out  1  one-cycle pulse.
- parity_error_o  out  1  one-cycle pulse.
- overrun_error_o  out  1  one-cycle pulse.

## Operation
- Reset values:
  - All outputs 0; m_axis_tdata 0.
  - FIFO empty; state IDLE.
  - Both synchroniser flops 1.
- rxd_i passes through a 2-flop synchroniser; "line" below means the synchronised value.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE: if line=0 and prescale_i≠0, latch prescale_i into an internal register and go to START. The latched value is used for the whole frame; prescale_i changes mid-frame are ignored. If prescale_i=0, stay in IDLE.
  - START: wait to mid-bit, then sample. Line=1 means false start: return to IDLE with no error. Line=0 means go to DATA.
  - DATA: take DATA_WIDTH samples, LSB first, shifted into a data register.
  - PARITY (only if PARITY≠0): sample the parity bit. Odd parity: data bits plus parity bit must XOR to 1. Even parity: they must XOR to 0.
  - STOP: take STOP_BITS samples, each required to be 1.
- End of frame, evaluated at the last stop sample, in priority order:
  - Any stop sample 0: frame_error_o pulses, character discarded, go to BREAK.
  - Else parity mismatch: parity_error_o pulses, character discarded, go to IDLE.
  - Else FIFO full and no pop this cycle: overrun_error_o pulses, character discarded, go to IDLE.
  - Else: character pushed, go to IDLE.
- BREAK: stay until line=1, then go to IDLE. A held-low line produces exactly one frame error, not repeated frames.
- FIFO:
  - Pop happens when m_axis_tvalid && m_axis_tready.
  - Push and pop may occur in the same cycle. When full, a simultaneous pop makes room, so the push is accepted and the count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH; fifo_count_o saturates at FIFO_DEPTH by construction.
  - m_axis_tdata is meaningful only while tvalid=1.
- Reset mid-frame: frame aborted, FIFO emptied, no error pulse.

## Timing
- Let P = latched prescale. Call cycle 0 the cycle IDLE sees line=0.
- Sample times:
  - Start bit sampled at cycle 4P.
  - Data bit k (k = 0..DATA_WIDTH-1) sampled at cycle 4P + 8P(k+1).
  - Parity and stop bits follow at the same 8P spacing.
- The FIFO write is registered at the last stop sample; m_axis_tvalid and the incremented fifo_count_o become visible on the next cycle.
- Pin to tvalid latency: 2 synchroniser cycles + the sample times above + 1 cycle.
- Error pulses assert the cycle after the last stop sample, for exactly 1 cycle.
- A pop updates tvalid, tdata and fifo_count_o on the next cycle. Back-to-back pops are sustained at 1 per cycle.
- busy_o rises the cycle after start detection and falls the cycle after returning to IDLE. From BREAK, it falls when the line returns high.
- A new start bit may be detected on the cycle immediately after returning to IDLE, so a frame with 1 stop bit can be followed directly by the next start bit.

## Test plan
- Defaults, P=1, tready=1, send 0xA5 as 8N1: tvalid high 1 cycle with tdata=0xA5, fifo_count_o returns to 0, no error pulses.
- Glitch: rxd_i low for 3 cycles, then high: busy_o pulses, returns to IDLE, no push, no error.
- PARITY=2, send 0x03 with parity bit 1: parity_error_o pulses and no push. Then send 0x03 with parity bit 0: 0x03 pushed.
- Stop bit driven 0, then line held low for 100 cycles: exactly one frame_error_o pulse, busy_o stays high until release, then 0x5A is received correctly.
- FIFO_DEPTH=4, tready=0, send 0x01..0x05: fifo_count_o=4 and overrun_error_o pulses on 0x05. Raise tready: 0x01..0x04 drained in order. Also cover a push coinciding with a pop while full: no overrun, count stays 4.
- Assert rst during DATA of a frame while 2 entries are buffered: next cycle all outputs are 0 and FIFO empty. After rst, a fresh 0xC3 is received correctly.
